// File: rtl/btn_evt_pkg.sv
// Shared types and default timing for the button event classifier.
package btn_evt_pkg;
  localparam int CLK_HZ       = 10_000_000;
  localparam int LONG_CNT_DEF = CLK_HZ;            // 1 s hold
  localparam int DBL_CNT_DEF  = CLK_HZ / 10 * 3;   // 300 ms double-click window

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } btn_state_t;
endpackage

// File: rtl/button_event_classifier_edge_detect.sv
// Registers the previous button level and flags rises/falls; tracks regardless of en.
module edge_detect (
  input  logic clk,
  input  logic rst_,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic din_q;

  always_ff @(posedge clk) begin
    if (rst_) din_q <= 1'b0;
    else      din_q <= din;
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;
endmodule

// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into press/release/click/double/long pulses.
module button_event_classifier
  import btn_evt_pkg::*;
#(
  parameter int LONG_CNT = LONG_CNT_DEF,
  parameter int DBL_CNT  = DBL_CNT_DEF,
  parameter int CNT_W    = 24
) (
  input  logic clk,
  input  logic rst_,
  input  logic en,
  input  logic din,
  output logic press,
  output logic rel,          // falling-edge pulse; "release" is a reserved word
  output logic click,
  output logic dbl_click,
  output logic long_press,
  output logic busy
);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CNT - 1);

  btn_state_t       state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             rise, fall;
  logic             press_d, rel_d, click_d, dbl_d, long_d;

  edge_detect u_edge (
    .clk  (clk),
    .rst_ (rst_),
    .din  (din),
    .rise (rise),
    .fall (fall)
  );

  // Edges are tested before terminal counts so an edge always wins.
  always_comb begin
    state_d = state;
    press_d = 1'b0;
    rel_d   = 1'b0;
    click_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
        PRESSED: if (fall) begin
          rel_d   = 1'b1;
          state_d = WAIT_SECOND;
        end else if (cnt == LONG_TC) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
        LONG_HELD: if (fall) begin
          rel_d   = 1'b1;
          state_d = IDLE;
        end
        WAIT_SECOND: if (rise) begin
          press_d = 1'b1;
          state_d = SECOND_PRESSED;
        end else if (cnt == DBL_TC) begin
          click_d = 1'b1;
          state_d = IDLE;
        end
        SECOND_PRESSED: if (fall) begin
          rel_d   = 1'b1;
          dbl_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt == LONG_TC) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state      <= IDLE;
      cnt        <= '0;
      press      <= 1'b0;
      rel        <= 1'b0;
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_d;
      press      <= press_d;
      rel        <= rel_d;
      click      <= click_d;
      dbl_click  <= dbl_d;
      long_press <= long_d;
      if (!en || state_d != state) cnt <= '0;
      else if (cnt != '1)          cnt <= cnt + 1'b1;
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_button_event_classifier.sv
// Directed scenario bench for button_event_classifier with LONG_CNT=20, DBL_CNT=10.
module tb_button_event_classifier;
  logic clk = 1'b0;
  logic rst_, en, din;
  logic press, rel, click, dbl_click, long_press, busy;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int n_press, n_rel, n_click, n_dbl, n_long, multi;
  int t_press, t_press1, t_rel, t_rel1, t_click, t_dbl, t_long;
  int b;

  button_event_classifier #(.LONG_CNT(20), .DBL_CNT(10), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .en         (en),
    .din        (din),
    .press      (press),
    .rel        (rel),
    .click      (click),
    .dbl_click  (dbl_click),
    .long_press (long_press),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic clr();
    n_press = 0; n_rel = 0; n_click = 0; n_dbl = 0; n_long = 0; multi = 0;
    t_press = -1; t_press1 = -1; t_rel = -1; t_rel1 = -1;
    t_click = -1; t_dbl = -1; t_long = -1;
  endtask

  // One clock: drive din, take the edge, then log pulses seen after it.
  task automatic tick(input logic d);
    din = d;
    @(posedge clk);
    #1;
    cyc++;
    if (press)      begin n_press++; t_press = cyc; if (n_press == 1) t_press1 = cyc; end
    if (rel)        begin n_rel++;   t_rel = cyc;   if (n_rel == 1)   t_rel1 = cyc;   end
    if (click)      begin n_click++; t_click = cyc; end
    if (dbl_click)  begin n_dbl++;   t_dbl = cyc;   end
    if (long_press) begin n_long++;  t_long = cyc;  end
    if (int'(click) + int'(dbl_click) + int'(long_press) > 1) multi++;
  endtask

  task automatic test_reset();
    rst_ = 1'b1; en = 1'b1; clr();
    repeat (3) tick(1'b0);
    checks++;
    if ({press, rel, click, dbl_click, long_press, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b expected=000000",
               {press, rel, click, dbl_click, long_press, busy});
    end
    rst_ = 1'b0;
    tick(1'b0);
    checks++;
    if ({press, rel, click, dbl_click, long_press, busy} !== 6'b0) begin
      failures++;
      $display("FAIL idle_outputs actual=%b expected=000000",
               {press, rel, click, dbl_click, long_press, busy});
    end
  endtask

  task automatic test_reset_din_high();
    rst_ = 1'b1; clr();
    tick(1'b1);
    checks++;
    if (press !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_din_high_hold actual=%b%b expected=00", press, busy);
    end
    rst_ = 1'b0;
    tick(1'b1);
    checks++;
    if (press !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_din_high_press actual=%b%b expected=11", press, busy);
    end
    tick(1'b1);
    repeat (15) tick(1'b0);
    checks++;
    if (n_press != 1 || n_rel != 1 || n_click != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_din_high_seq actual=p%0d r%0d c%0d busy%b expected=p1 r1 c1 busy0",
               n_press, n_rel, n_click, busy);
    end
  endtask

  task automatic test_single_click();
    clr(); b = cyc + 1;
    repeat (5)  tick(1'b1);
    repeat (20) tick(1'b0);
    checks++;
    if (t_press != b || t_rel != b + 5 || t_click != b + 15) begin
      failures++;
      $display("FAIL click_timing actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
               t_press, t_rel, t_click, b, b + 5, b + 15);
    end
    checks++;
    if (n_press != 1 || n_rel != 1 || n_click != 1 || n_dbl != 0 || n_long != 0) begin
      failures++;
      $display("FAIL click_counts actual=p%0d r%0d c%0d d%0d l%0d expected=p1 r1 c1 d0 l0",
               n_press, n_rel, n_click, n_dbl, n_long);
    end
  endtask

  task automatic test_double_click();
    clr(); b = cyc + 1;
    repeat (3)  tick(1'b1);
    repeat (4)  tick(1'b0);
    repeat (3)  tick(1'b1);
    repeat (20) tick(1'b0);
    checks++;
    if (n_press != 2 || n_rel != 2 || n_dbl != 1 || n_click != 0 || n_long != 0) begin
      failures++;
      $display("FAIL dbl_counts actual=p%0d r%0d d%0d c%0d l%0d expected=p2 r2 d1 c0 l0",
               n_press, n_rel, n_dbl, n_click, n_long);
    end
    checks++;
    if (t_press1 != b || t_rel1 != b + 3 || t_press != b + 7 || t_rel != b + 10 || t_dbl != b + 10) begin
      failures++;
      $display("FAIL dbl_timing actual=%0d/%0d/%0d/%0d/%0d expected=%0d/%0d/%0d/%0d/%0d",
               t_press1, t_rel1, t_press, t_rel, t_dbl, b, b + 3, b + 7, b + 10, b + 10);
    end
  endtask

  task automatic test_long_press();
    clr(); b = cyc + 1;
    repeat (30) tick(1'b1);
    repeat (20) tick(1'b0);
    checks++;
    if (t_press != b || t_long != b + 20 || t_rel != b + 30) begin
      failures++;
      $display("FAIL long_timing actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
               t_press, t_long, t_rel, b, b + 20, b + 30);
    end
    checks++;
    if (n_long != 1 || n_click != 0 || n_dbl != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL long_counts actual=l%0d c%0d d%0d busy%b expected=l1 c0 d0 busy0",
               n_long, n_click, n_dbl, busy);
    end
  endtask

  task automatic test_fall_on_terminal();
    clr(); b = cyc + 1;
    repeat (20) tick(1'b1);
    repeat (20) tick(1'b0);
    checks++;
    if (n_long != 0 || t_rel != b + 20 || t_click != b + 30 || n_click != 1) begin
      failures++;
      $display("FAIL terminal_fall actual=l%0d rel%0d click%0d n%0d expected=l0 rel%0d click%0d n1",
               n_long, t_rel, t_click, n_click, b + 20, b + 30);
    end
  endtask

  task automatic test_reset_mid_window();
    clr(); b = cyc + 1;
    repeat (3) tick(1'b1);
    repeat (3) tick(1'b0);
    rst_ = 1'b1;
    tick(1'b0);
    rst_ = 1'b0;
    checks++;
    if ({press, rel, click, dbl_click, long_press, busy} !== 6'b0) begin
      failures++;
      $display("FAIL midwin_reset_outputs actual=%b expected=000000",
               {press, rel, click, dbl_click, long_press, busy});
    end
    repeat (20) tick(1'b0);
    checks++;
    if (n_click != 0 || t_rel != b + 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midwin_no_click actual=c%0d rel%0d busy%b expected=c0 rel%0d busy0",
               n_click, t_rel, busy, b + 3);
    end
  endtask

  task automatic test_enable_gating();
    clr();
    repeat (3) tick(1'b1);
    repeat (2) tick(1'b0);
    en = 1'b0;
    tick(1'b0);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL en_low_busy actual=%b expected=0", busy);
    end
    repeat (2) tick(1'b0);
    repeat (3) tick(1'b1);
    en = 1'b1;
    repeat (3)  tick(1'b1);
    repeat (15) tick(1'b0);
    checks++;
    if (n_press != 1 || n_rel != 1 || n_click != 0 || n_dbl != 0 || n_long != 0) begin
      failures++;
      $display("FAIL en_gating actual=p%0d r%0d c%0d d%0d l%0d expected=p1 r1 c0 d0 l0",
               n_press, n_rel, n_click, n_dbl, n_long);
    end
    clr(); b = cyc + 1;
    repeat (5)  tick(1'b1);
    repeat (20) tick(1'b0);
    checks++;
    if (t_press != b || t_rel != b + 5 || t_click != b + 15 || n_click != 1) begin
      failures++;
      $display("FAIL en_after_click actual=%0d/%0d/%0d n%0d expected=%0d/%0d/%0d n1",
               t_press, t_rel, t_click, n_click, b, b + 5, b + 15);
    end
  endtask

  int total_multi = 0;

  initial begin
    rst_ = 1'b1; en = 1'b1; din = 1'b0;
    test_reset();
    test_reset_din_high();
    test_single_click();        total_multi += multi;
    test_double_click();        total_multi += multi;
    test_long_press();          total_multi += multi;
    test_fall_on_terminal();    total_multi += multi;
    test_reset_mid_window();    total_multi += multi;
    test_enable_gating();       total_multi += multi;
    checks++;
    if (total_multi != 0) begin
      failures++;
      $display("FAIL one_event_per_cycle actual=%0d expected=0", total_multi);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_event_classifier.md
# button_event_classifier

Consumes the debounced, glitch-free button level from the debouncer and classifies it into single-cycle event pulses: press, release, single click, double click and long press. It runs on the same 10 MHz system clock and feeds control logic that needs discrete user events rather than a raw level. All timing windows are cycle counts, set by parameters.

## Interface
- `LONG_CNT`, default 10_000_000: hold duration for a long press (1 s at 10 MHz); legal range ≥2 and ≤2^CNT_W.
- `DBL_CNT`, default 3_000_000: window after a release in which a second press makes a double click (300 ms); legal range ≥2 and ≤2^CNT_W.
- `CNT_W`, default 24: width of the window counter.
- `clk` input 1: system clock, rising edge.
- `rst_` input 1: synchronous, active-high reset. It is sampled on the `clk` rising edge only.
- `en` input 1: classifier enable.
- `din` input 1: debounced button level, 1 = pressed.
- `press` output 1: one-cycle pulse on each rising edge of `din`.
- `release` output 1: one-cycle pulse on each falling edge of `din`.
- `click` output 1: one-cycle pulse when a short press is not followed by a second press within the window.
- `dbl_click` output 1: one-cycle pulse when the second short press of a pair is released.
- `long_press` output 1: one-cycle pulse when a hold reaches `LONG_CNT`.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- `din_q` is a register that holds the previous `din`. A rise is `din & !din_q`; a fall is `!din & din_q`.
- The FSM has five states: IDLE, PRESSED, LONG_HELD, WAIT_SECOND and SECOND_PRESSED. `cnt` clears to 0 on every state change and otherwise increments by 1 per cycle. It saturates and never wraps.
- IDLE, on a rise: pulse `press` and go to PRESSED.
- PRESSED:
  - On a fall: pulse `release` and go to WAIT_SECOND.
  - Else, if `cnt == LONG_CNT-1`: pulse `long_press` and go to LONG_HELD.
- LONG_HELD, on a fall: pulse `release` and go to IDLE. No click is generated after a long press.
- WAIT_SECOND:
  - On a rise: pulse `press` and go to SECOND_PRESSED.
  - Else, if `cnt == DBL_CNT-1`: pulse `click` and go to IDLE.
- SECOND_PRESSED:
  - On a fall: pulse `release` and `dbl_click` in the same cycle, then go to IDLE.
  - Else, if `cnt == LONG_CNT-1`: pulse `long_press` and go to LONG_HELD. No `dbl_click` is generated in this case.
- Simultaneous events: an edge of `din` always has priority over a terminal count in the same cycle.
- `en` low, checked after reset:
  - The state forces to IDLE and `cnt` to 0.
  - All pulse outputs are 0 and no pending click is emitted.
  - `din_q` still tracks `din`, so re-enabling while the button is held produces no spurious `press`.
- Reset:
  - State = IDLE, `cnt` = 0, `din_q` = 0, and every output = 0.
  - Reset has priority over `en`.
  - If reset is applied mid-window, the pending click or double click is discarded.
  - If `din` is high when reset releases, `press` fires one cycle later, because `din_q` is 0.

## Timing
- All outputs are registered.
- Event latency is 1 cycle: `din` is first sampled high at edge N, and `press` is high for the cycle after edge N. `release` behaves the same way for a fall.
- Long press: with `press` high at cycle T, `long_press` is high at T+LONG_CNT if `din` stays high.
- Click: with `release` high at cycle R, `click` is high at R+DBL_CNT if there is no rise.
- Every pulse is exactly one cycle wide, and there is at most one classified event (`click`, `dbl_click`, `long_press`) per cycle.
- `busy` is registered with the state, so it is high in the same cycle as the `press` that leaves IDLE.

## Structure
- Shared package `btn_evt_pkg`:
  - the state enum `btn_state_t`;
  - the default constants `LONG_CNT_DEF` and `DBL_CNT_DEF`;
  - `CLK_HZ = 10_000_000`.
- One natural sub-module is `edge_detect`. It holds the `din_q` register and has rise/fall outputs, with its own `en`-independent tracking. The FSM and the counter stay in the top level.

## Test plan
All scenarios use LONG_CNT=20 and DBL_CNT=10. N is the first cycle at which `din` is sampled high.
- **Single click.** `din` is 1 for 5 cycles starting at N, then 0. Required: `press` at N+1, `release` at N+6, `click` at N+16, and nothing else.
- **Double click.** `din` is 1 for 3 cycles, 0 for 4 cycles, then 1 for 3 cycles. Required: two `press` pulses, two `release` pulses, one `dbl_click` coincident with the second `release`, and no `click`.
- **Long press.** `din` is 1 for 30 cycles. Required: `press` at N+1, `long_press` at N+21, `release` at N+31, and no `click` afterwards.
- **Boundary, fall on the terminal count.** `din` falls on exactly the cycle where `cnt` = 19 in PRESSED. Required: `release` with no `long_press`, then `click` 10 cycles later.
- **Reset mid-window.** Assert `rst_` for 1 cycle, 3 cycles after a `release`. Required: no `click`, `busy` = 0 the next cycle, and all outputs 0.
- **Enable gating.** Drop `en` while in WAIT_SECOND, then raise it while `din` = 1. Required: no `click` and no `press`; the next full press/release behaves as a single click.
